trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning record slots; power of two, 4..256.
REQ-002 SHALL have parameter NREGS, default 2, meaning watched 32-bit register channels, 1..8.
REQ-003 SHALL have parameter POST_W, default 8, meaning width of post-trigger count.
REQ-004 SHALL define record width RW = 30 + 32 + 32*NREGS, packed as {pc, instr, regs}.
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1, the sole clock.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port retire, input, 1, meaning an instruction retires this cycle.
REQ-009 SHALL have port pc, input, 30, meaning the word-address PC of the retiring instruction.
REQ-010 SHALL have port instr, input, 32, meaning the retiring instruction word.
REQ-011 SHALL have port regs, input, 32*NREGS, meaning watched register values, channel 0 in the LSBs.
REQ-012 SHALL have port mode, input, 2, meaning 0 CIRCULAR, 1 ONESHOT, 2 TRIGGER, 3 reserved and treated as ONESHOT.
REQ-013 SHALL have port trig_pc, input, 30, meaning the trigger PC.
REQ-014 SHALL have port post_count, input, POST_W, meaning records captured after the trigger record.
REQ-015 SHALL have ports start and stop, input, 1 each, meaning single-cycle pulses.
REQ-016 SHALL have port rd_en, input, 1, meaning pop the oldest record.
REQ-017 SHALL have port rd_data, output, RW, meaning the popped record.
REQ-018 SHALL have port rd_valid, output, 1, meaning rd_data is valid this cycle.
REQ-019 SHALL have port count, output, clog2(DEPTH)+1, meaning records held.
REQ-020 SHALL have ports state, output, 2, and overflow, output, 1.

Function
REQ-021 SHALL implement the FSM IDLE=0, ARMED=1, POST=2, DONE=3, reflected on state.
REQ-022 SHALL move IDLE or DONE to ARMED on start, clearing wptr, count and overflow in the same edge.
REQ-023 SHALL ignore start in ARMED or POST.
REQ-024 SHALL move ARMED or POST to DONE on stop; when start and stop coincide, start SHALL win in IDLE or DONE and stop SHALL win otherwise.
REQ-025 SHALL, in ARMED or POST with retire=1, write the record at wptr, advance wptr modulo DEPTH, and increment count, saturating at DEPTH.
REQ-026 SHALL, in CIRCULAR with count==DEPTH, overwrite the oldest record and set the sticky overflow flag; CIRCULAR ends only on stop.
REQ-027 SHALL, in ONESHOT, enter DONE on the edge that writes record DEPTH; no overwrite SHALL occur.
REQ-028 SHALL, in TRIGGER, behave as CIRCULAR in ARMED until retire with pc==trig_pc, capture that record, and move to POST with remaining = post_count.
REQ-029 SHALL, in POST, decrement remaining for each captured record and enter DONE on the edge that captures when remaining==1.
REQ-030 SHALL enter DONE directly from ARMED on the trigger edge when post_count==0.
REQ-031 SHALL latch mode, trig_pc and post_count on start; later changes SHALL have no effect until the next start.
REQ-032 SHALL accept rd_en only in IDLE or DONE with count>0; otherwise rd_en SHALL be ignored and rd_valid SHALL stay 0.
REQ-033 SHALL compute the read address as (wptr - count) mod DEPTH, return rd_data with rd_valid=1 on the cycle after an accepted rd_en, and decrement count.
REQ-034 SHALL accept rd_en back-to-back, one record per cycle, oldest first.
REQ-035 SHALL leave rd_data unchanged while rd_valid=0.

Reset
REQ-036 SHALL, when rst_n=0 at a clk edge, set state=IDLE, wptr=0, count=0, overflow=0, rd_valid=0, rd_data=0 and remaining=0.
REQ-037 SHALL clear all state on reset even mid-capture or mid-readout; memory contents are not reset, but count=0 makes them unreadable.
REQ-038 SHALL ignore start, stop, retire and rd_en while rst_n=0.

Verification (DEPTH=4, NREGS=2)
REQ-039 SHALL cover ONESHOT: start, then 6 retires with pc 0..5 -> state=DONE after the 4th, count=4; 4 pops return pc 0,1,2,3 with overflow=0.
REQ-040 SHALL cover CIRCULAR: 6 retires with pc 0..5, then stop -> count=4, overflow=1; pops return pc 2,3,4,5.
REQ-041 SHALL cover TRIGGER: trig_pc=0x10 and post_count=2, with retires at pc 0x0C..0x14 in steps of 1 -> DONE after pc 0x12; pops return 0x0F, 0x10, 0x11, 0x12.
REQ-042 SHALL cover TRIGGER with post_count=0 and trig_pc=3, with retires at pc 0..3 -> DONE on the pc 3 edge, count=4.
REQ-043 SHALL cover rd_en while ARMED, and rd_en with count=0 in DONE -> rd_valid stays 0 and count is unchanged.
REQ-044 SHALL cover rst_n=0 for one cycle in POST after 2 captures -> state=IDLE, count=0; a subsequent rd_en yields no rd_valid.

Source files
------------

// File: rtl/trace_buffer.sv
// trace_buffer: instruction-retire trace capture buffer.
//
// Captures {pc, instr, regs} records of retiring instructions into a
// DEPTH-entry ring while ARMED/POST. Capture policy is latched on start:
//   CIRCULAR - capture until stop, overwriting the oldest (sticky overflow)
//   ONESHOT  - capture DEPTH records then stop (mode 3 behaves the same)
//   TRIGGER  - circular until pc==trig_pc, then post_count more records
// Records are popped oldest-first in IDLE/DONE, one per cycle.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   retire, pc, instr,     retiring-instruction record inputs
//   regs                   (regs channel 0 in LSBs)
//   mode, trig_pc,         capture configuration, latched on start
//   post_count
//   start, stop            single-cycle control pulses
//   rd_en                  pop oldest record
//   rd_data, rd_valid      popped record, valid the cycle after rd_en
//   count                  records held
//   state, overflow        FSM state (IDLE/ARMED/POST/DONE), sticky overflow
module trace_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NREGS  = 2,
  parameter int unsigned POST_W = 8,
  localparam int unsigned RW = 30 + 32 + 32 * NREGS,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                retire,
  input  logic [29:0]         pc,
  input  logic [31:0]         instr,
  input  logic [32*NREGS-1:0] regs,
  input  logic [1:0]          mode,
  input  logic [29:0]         trig_pc,
  input  logic [POST_W-1:0]   post_count,
  input  logic                start,
  input  logic                stop,
  input  logic                rd_en,
  output logic [RW-1:0]       rd_data,
  output logic                rd_valid,
  output logic [CW-1:0]       count,
  output logic [1:0]          state,
  output logic                overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_CIRC    = 2'd0,
    M_ONESHOT = 2'd1,
    M_TRIGGER = 2'd2,
    M_RSVD    = 2'd3
  } mode_t;

  logic [RW-1:0] mem [DEPTH];

  state_t            state_q,     state_d;
  logic [AW-1:0]     wptr_q,      wptr_d;
  logic [CW-1:0]     count_q,     count_d;
  logic              overflow_q,  overflow_d;
  logic              rd_valid_q,  rd_valid_d;
  logic [RW-1:0]     rd_data_q,   rd_data_d;
  logic [POST_W-1:0] remaining_q, remaining_d;
  mode_t             mode_q,      mode_d;
  logic [29:0]       trig_pc_q,   trig_pc_d;
  logic [POST_W-1:0] post_q,      post_d;

  logic          we;
  logic [RW-1:0] wdata;
  logic [AW-1:0] raddr;
  logic          full;
  logic          oneshot;

  assign wdata   = {pc, instr, regs};
  // count==DEPTH has zero low bits, so this also yields wptr when full.
  assign raddr   = wptr_q - count_q[AW-1:0];
  assign full    = (count_q == CW'(DEPTH));
  assign oneshot = (mode_q == M_ONESHOT) || (mode_q == M_RSVD);

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    trig_pc_d   = trig_pc_q;
    post_d      = post_q;
    we          = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = ARMED;
          wptr_d      = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          remaining_d = '0;
          mode_d      = mode_t'(mode);
          trig_pc_d   = trig_pc;
          post_d      = post_count;
        end else if (rd_en && (count_q != '0)) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem[raddr];
          count_d    = count_q - CW'(1);
        end
      end

      ARMED, POST: begin
        // A full ONESHOT buffer never overwrites.
        if (retire && !(oneshot && full)) begin
          we     = 1'b1;
          wptr_d = wptr_q + AW'(1);
          if (full) overflow_d = 1'b1;
          else      count_d    = count_q + CW'(1);
        end

        if (stop) begin
          state_d = DONE;
        end else if (retire) begin
          if (state_q == ARMED) begin
            if (oneshot) begin
              if (full || (count_q == CW'(DEPTH - 1))) state_d = DONE;
            end else if ((mode_q == M_TRIGGER) && (pc == trig_pc_q)) begin
              remaining_d = post_q;
              state_d     = (post_q == '0) ? DONE : POST;
            end
          end else begin
            remaining_d = remaining_q - POST_W'(1);
            if (remaining_q <= POST_W'(1)) state_d = DONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      remaining_q <= '0;
      mode_q      <= M_CIRC;
      trig_pc_q   <= '0;
      post_q      <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      trig_pc_q   <= trig_pc_d;
      post_q      <= post_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && we) mem[wptr_q] <= wdata;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign state    = state_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: table-driven directed bench for trace_buffer
// (DEPTH=4, NREGS=2). Each vector is applied for one clock; outputs are
// checked 1ns after the edge against hand-computed expectations.
module tb_trace_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned NREGS  = 2;
  localparam int unsigned POST_W = 8;
  localparam int unsigned RW     = 30 + 32 + 32 * NREGS;

  logic                clk;
  logic                rst_n;
  logic                retire;
  logic [29:0]         pc;
  logic [31:0]         instr;
  logic [32*NREGS-1:0] regs;
  logic [1:0]          mode;
  logic [29:0]         trig_pc;
  logic [POST_W-1:0]   post_count;
  logic                start;
  logic                stop;
  logic                rd_en;
  logic [RW-1:0]       rd_data;
  logic                rd_valid;
  logic [2:0]          count;
  logic [1:0]          state;
  logic                overflow;

  trace_buffer #(.DEPTH(DEPTH), .NREGS(NREGS), .POST_W(POST_W)) dut (
    .clk(clk), .rst_n(rst_n), .retire(retire), .pc(pc), .instr(instr),
    .regs(regs), .mode(mode), .trig_pc(trig_pc), .post_count(post_count),
    .start(start), .stop(stop), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .state(state), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [29:0] p);
    return {2'b00, p} ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [32*NREGS-1:0] regs_of(input logic [29:0] p);
    return {{2'b00, p} + 32'h1000_0002, {2'b00, p} + 32'h2000_0001};
  endfunction

  function automatic logic [RW-1:0] rec_of(input logic [29:0] p);
    return {p, instr_of(p), regs_of(p)};
  endfunction

  typedef struct {
    bit          rst_n, start, stop, retire, rd_en;
    logic [29:0] pc;
    logic [1:0]  mode;
    logic [29:0] tpc;
    logic [7:0]  post;
    logic [1:0]  es;
    logic [2:0]  ec;
    bit          eo, erv, chk;
    logic [29:0] ep;
  } vec_t;

  vec_t        tbl[$];
  logic [1:0]  c_mode;
  logic [29:0] c_tpc;
  logic [7:0]  c_post;
  int unsigned total;
  int unsigned bad;

  // chk: compare rd_data against rec_of(ep) (pop result, or held value).
  task automatic v(input bit rn, st, sp, rt, input logic [29:0] p, input bit rd,
                   input logic [1:0] es, input logic [2:0] ec, input bit eo,
                   input bit erv, input bit chk, input logic [29:0] ep);
    vec_t x;
    x.rst_n = rn; x.start = st; x.stop = sp; x.retire = rt; x.rd_en = rd;
    x.pc = p; x.mode = c_mode; x.tpc = c_tpc; x.post = c_post;
    x.es = es; x.ec = ec; x.eo = eo; x.erv = erv; x.chk = chk; x.ep = ep;
    tbl.push_back(x);
  endtask

  task automatic check(input string name, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; retire = 1'b0; pc = '0; instr = '0; regs = '0;
    mode = '0; trig_pc = '0; post_count = '0; start = 1'b0; stop = 1'b0;
    rd_en = 1'b0;
    c_mode = 2'd1; c_tpc = '0; c_post = '0;

    // reset
    v(0,0,0,0, 0,0, 2'd0,3'd0,0,0,0, 0);
    // ONESHOT; mode input changes after start and must be ignored
    v(1,1,0,0, 0,0, 2'd1,3'd0,0,0,0, 0);
    c_mode = 2'd0;
    v(1,0,0,1, 0,0, 2'd1,3'd1,0,0,0, 0);
    v(1,0,0,1, 1,0, 2'd1,3'd2,0,0,0, 0);
    v(1,0,0,1, 2,0, 2'd1,3'd3,0,0,0, 0);
    v(1,0,0,1, 3,0, 2'd3,3'd4,0,0,0, 0);
    v(1,0,0,1, 4,0, 2'd3,3'd4,0,0,0, 0);
    v(1,0,0,1, 5,0, 2'd3,3'd4,0,0,0, 0);
    v(1,0,0,0, 0,1, 2'd3,3'd3,0,1,1, 0);
    v(1,0,0,0, 0,1, 2'd3,3'd2,0,1,1, 1);
    v(1,0,0,0, 0,1, 2'd3,3'd1,0,1,1, 2);
    v(1,0,0,0, 0,1, 2'd3,3'd0,0,1,1, 3);
    // rd_en with count=0 in DONE: ignored, rd_data held
    v(1,0,0,0, 0,1, 2'd3,3'd0,0,0,1, 3);
    // CIRCULAR
    v(1,1,0,0, 0,0, 2'd1,3'd0,0,0,0, 0);
    v(1,0,0,1, 0,0, 2'd1,3'd1,0,0,0, 0);
    v(1,0,0,1, 1,0, 2'd1,3'd2,0,0,0, 0);
    v(1,0,0,1, 2,0, 2'd1,3'd3,0,0,0, 0);
    v(1,0,0,1, 3,0, 2'd1,3'd4,0,0,0, 0);
    v(1,0,0,1, 4,0, 2'd1,3'd4,1,0,0, 0);
    v(1,0,0,1, 5,0, 2'd1,3'd4,1,0,0, 0);
    // rd_en while ARMED is ignored
    v(1,0,0,0, 0,1, 2'd1,3'd4,1,0,1, 3);
    v(1,0,1,0, 0,0, 2'd3,3'd4,1,0,0, 0);
    v(1,0,0,0, 0,1, 2'd3,3'd3,1,1,1, 2);
    v(1,0,0,0, 0,1, 2'd3,3'd2,1,1,1, 3);
    v(1,0,0,0, 0,1, 2'd3,3'd1,1,1,1, 4);
    v(1,0,0,0, 0,1, 2'd3,3'd0,1,1,1, 5);
    // TRIGGER trig_pc=0x10, post_count=2
    c_mode = 2'd2; c_tpc = 30'h10; c_post = 8'd2;
    v(1,1,0,0, 0,0, 2'd1,3'd0,0,0,0, 0);
    c_tpc = 30'h0D; c_post = 8'd0;
    v(1,0,0,1, 30'h0C,0, 2'd1,3'd1,0,0,0, 0);
    v(1,0,0,1, 30'h0D,0, 2'd1,3'd2,0,0,0, 0);
    v(1,0,0,1, 30'h0E,0, 2'd1,3'd3,0,0,0, 0);
    v(1,0,0,1, 30'h0F,0, 2'd1,3'd4,0,0,0, 0);
    v(1,0,0,1, 30'h10,0, 2'd2,3'd4,1,0,0, 0);
    v(1,0,0,1, 30'h11,0, 2'd2,3'd4,1,0,0, 0);
    v(1,0,0,1, 30'h12,0, 2'd3,3'd4,1,0,0, 0);
    v(1,0,0,1, 30'h13,0, 2'd3,3'd4,1,0,0, 0);
    v(1,0,0,0, 0,1, 2'd3,3'd3,1,1,1, 30'h0F);
    v(1,0,0,0, 0,1, 2'd3,3'd2,1,1,1, 30'h10);
    v(1,0,0,0, 0,1, 2'd3,3'd1,1,1,1, 30'h11);
    v(1,0,0,0, 0,1, 2'd3,3'd0,1,1,1, 30'h12);
    // TRIGGER post_count=0, trig_pc=3; start+stop in DONE: start wins
    c_tpc = 30'd3; c_post = 8'd0;
    v(1,1,1,0, 0,0, 2'd1,3'd0,0,0,0, 0);
    v(1,0,0,1, 0,0, 2'd1,3'd1,0,0,0, 0);
    v(1,0,0,1, 1,0, 2'd1,3'd2,0,0,0, 0);
    v(1,0,0,1, 2,0, 2'd1,3'd3,0,0,0, 0);
    v(1,0,0,1, 3,0, 2'd3,3'd4,0,0,0, 0);
    // start+stop in ARMED: stop wins
    c_mode = 2'd0;
    v(1,1,0,0, 0,0, 2'd1,3'd0,0,0,0, 0);
    v(1,1,1,0, 0,0, 2'd3,3'd0,0,0,0, 0);
    // reset in POST after 2 captures; start in POST ignored
    c_mode = 2'd2; c_tpc = 30'h100; c_post = 8'd5;
    v(1,1,0,0, 0,0, 2'd1,3'd0,0,0,0, 0);
    v(1,0,0,1, 30'h100,0, 2'd2,3'd1,0,0,0, 0);
    v(1,0,0,1, 30'h101,0, 2'd2,3'd2,0,0,0, 0);
    v(1,1,0,0, 0,0, 2'd2,3'd2,0,0,0, 0);
    v(0,0,0,1, 30'h102,1, 2'd0,3'd0,0,0,0, 0);
    v(1,0,0,0, 0,1, 2'd0,3'd0,0,0,0, 0);

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; start = tbl[i].start; stop = tbl[i].stop;
      retire = tbl[i].retire; rd_en = tbl[i].rd_en; pc = tbl[i].pc;
      instr = instr_of(tbl[i].pc); regs = regs_of(tbl[i].pc);
      mode = tbl[i].mode; trig_pc = tbl[i].tpc; post_count = tbl[i].post;
      @(posedge clk); #1;
      check($sformatf("v%0d state", i), RW'(state), RW'(tbl[i].es));
      check($sformatf("v%0d count", i), RW'(count), RW'(tbl[i].ec));
      check($sformatf("v%0d overflow", i), RW'(overflow), RW'(tbl[i].eo));
      check($sformatf("v%0d rd_valid", i), RW'(rd_valid), RW'(tbl[i].erv));
      if (tbl[i].chk)
        check($sformatf("v%0d rd_data", i), rd_data, rec_of(tbl[i].ep));
      if (i == 0)
        check("reset rd_data", rd_data, '0);
    end

    // Hand sequence: reset in mid-readout clears count, pops then yield nothing.
    rst_n = 1'b1; start = 1'b1; mode = 2'd1; retire = 1'b0; rd_en = 1'b0;
    stop = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; retire = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      pc = 30'(k + 8); instr = instr_of(pc); regs = regs_of(pc);
      @(posedge clk); #1;
    end
    retire = 1'b0; rd_en = 1'b1;
    @(posedge clk); #1;
    check("mid-read pop", rd_data, rec_of(30'd8));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset rd_valid", RW'(rd_valid), RW'(1'b0));
    check("post-reset count", RW'(count), RW'(3'd0));
    check("post-reset rd_data", rd_data, '0);
    rd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
